// File: rtl/tlight_ctrl.sv
// Traffic-light controller: NS/EW lamps, all-red clearance, tick-timed phases.
// Optional pedestrian walk phase compiled in with `define TLIGHT_PED_EN.
module tlight_ctrl #(
  parameter int TICKS_GREEN     = 8,
  parameter int TICKS_YELLOW    = 3,
  parameter int TICKS_ALLRED    = 1,
  parameter int TICKS_WALK      = 4,
  parameter int TICKS_MIN_GREEN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       walk,
  output logic [2:0] state
);

  localparam int MAX_GY = (TICKS_GREEN > TICKS_YELLOW) ?
                          TICKS_GREEN : TICKS_YELLOW;
  localparam int MAX_AW = (TICKS_ALLRED > TICKS_WALK) ?
                          TICKS_ALLRED : TICKS_WALK;
  localparam int MAXT   = (MAX_GY > MAX_AW) ? MAX_GY : MAX_AW;
  localparam int CW     = $clog2(MAXT + 1);

  localparam logic [1:0] L_RED = 2'd1;
  localparam logic [1:0] L_YEL = 2'd2;
  localparam logic [1:0] L_GRN = 2'd3;

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'd0,
    S_NS_YELLOW = 3'd1,
    S_ALLRED_A  = 3'd2,
    S_EW_GREEN  = 3'd3,
    S_EW_YELLOW = 3'd4,
    S_ALLRED_B  = 3'd5
`ifdef TLIGHT_PED_EN
    , S_PED_WALK = 3'd6
`endif
  } st_e;

  st_e           st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ns_q, ew_q;
  logic          early;
  logic          done;

  function automatic logic [CW-1:0] last_of(input st_e s);
    case (s)
      S_NS_GREEN, S_EW_GREEN:   last_of = CW'(TICKS_GREEN - 1);
      S_NS_YELLOW, S_EW_YELLOW: last_of = CW'(TICKS_YELLOW - 1);
`ifdef TLIGHT_PED_EN
      S_PED_WALK:               last_of = CW'(TICKS_WALK - 1);
`endif
      default:                  last_of = CW'(TICKS_ALLRED - 1);
    endcase
  endfunction

  function automatic logic [1:0] ns_of(input st_e s);
    case (s)
      S_NS_GREEN:  ns_of = L_GRN;
      S_NS_YELLOW: ns_of = L_YEL;
      default:     ns_of = L_RED;
    endcase
  endfunction

  function automatic logic [1:0] ew_of(input st_e s);
    case (s)
      S_EW_GREEN:  ew_of = L_GRN;
      S_EW_YELLOW: ew_of = L_YEL;
      default:     ew_of = L_RED;
    endcase
  endfunction

`ifdef TLIGHT_PED_EN
  logic pend_q, pend_d;
  logic ret_ew_q, ret_ew_d;
  logic walk_q;

  // Exit decisions use pend_q; a coinciding press only lands in pend_d.
  assign early = pend_q && (st_q == S_NS_GREEN || st_q == S_EW_GREEN) &&
                 (cnt_q >= CW'(TICKS_MIN_GREEN - 1));
`else
  logic ped_unused;
  assign ped_unused = ped_req;
  assign early      = 1'b0;
`endif

  assign done = (cnt_q == last_of(st_q)) || early;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
`ifdef TLIGHT_PED_EN
    pend_d   = pend_q;
    ret_ew_d = ret_ew_q;
    if (st_q != S_PED_WALK && ped_req) pend_d = 1'b1;
`endif
    if (tick) begin
      cnt_d = cnt_q + 1'b1;
      if (done) begin
        cnt_d = '0;
        case (st_q)
          S_NS_GREEN:  st_d = S_NS_YELLOW;
          S_NS_YELLOW: st_d = S_ALLRED_A;
          S_EW_GREEN:  st_d = S_EW_YELLOW;
          S_EW_YELLOW: st_d = S_ALLRED_B;
`ifdef TLIGHT_PED_EN
          S_ALLRED_A: begin
            st_d = pend_q ? S_PED_WALK : S_EW_GREEN;
            if (pend_q) begin
              pend_d   = 1'b0;
              ret_ew_d = 1'b1;
            end
          end
          S_ALLRED_B: begin
            st_d = pend_q ? S_PED_WALK : S_NS_GREEN;
            if (pend_q) begin
              pend_d   = 1'b0;
              ret_ew_d = 1'b0;
            end
          end
          S_PED_WALK: st_d = ret_ew_q ? S_EW_GREEN : S_NS_GREEN;
`else
          S_ALLRED_A:  st_d = S_EW_GREEN;
`endif
          default:     st_d = S_NS_GREEN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= S_ALLRED_B;
      cnt_q    <= '0;
      ns_q     <= L_RED;
      ew_q     <= L_RED;
`ifdef TLIGHT_PED_EN
      pend_q   <= 1'b0;
      ret_ew_q <= 1'b0;
      walk_q   <= 1'b0;
`endif
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      ns_q     <= ns_of(st_d);
      ew_q     <= ew_of(st_d);
`ifdef TLIGHT_PED_EN
      pend_q   <= pend_d;
      ret_ew_q <= ret_ew_d;
      walk_q   <= (st_d == S_PED_WALK);
`endif
    end
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign state    = st_q;
`ifdef TLIGHT_PED_EN
  assign walk     = walk_q;
`else
  assign walk     = 1'b0;
`endif

endmodule

// File: tb/tb_tlight_ctrl.sv
// Bench for tlight_ctrl: phase-table model checked every cycle,
// plus literal state/lamp expectations at hand-counted tick points.
module tb_tlight_ctrl;

`ifdef TLIGHT_PED_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif
  localparam int MIN_G = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] ns_light, ew_light;
  logic       walk;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // phase lengths indexed by state code: G Y R G Y R WALK
  int lens [7] = '{8, 3, 1, 8, 3, 1, 4};

  int m_st, m_cnt, m_ret;
  bit m_pend;

  tlight_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light),
    .walk(walk), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic int ns_exp(input int s);
    return (s == 0) ? 3 : (s == 1) ? 2 : 1;
  endfunction

  function automatic int ew_exp(input int s);
    return (s == 3) ? 3 : (s == 4) ? 2 : 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    int  nx;
    bit  np;
    bit  ex;
    if (reset) begin
      m_st <= 5; m_cnt <= 0; m_pend <= 1'b0; m_ret <= 0;
    end else begin
      np = m_pend | (PED && m_st != 6 && ped_req);
      if (tick) begin
        ex = (m_cnt == lens[m_st] - 1) ||
             (PED && m_pend && (m_st == 0 || m_st == 3) &&
              m_cnt >= MIN_G - 1);
        if (ex) begin
          if (m_st == 6) nx = m_ret;
          else if (PED && m_pend && (m_st == 2 || m_st == 5)) begin
            nx = 6;
            np = 1'b0;
            m_ret <= (m_st == 2) ? 3 : 0;
          end else nx = (m_st + 1) % 6;
          m_st  <= nx;
          m_cnt <= 0;
        end else m_cnt <= m_cnt + 1;
      end
      m_pend <= np;
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("model_state", int'(state), m_st);
      chk("model_ns", int'(ns_light), ns_exp(m_st));
      chk("model_ew", int'(ew_light), ew_exp(m_st));
      chk("model_walk", int'(walk), int'(m_st == 6));
    end
  end

  // pm: 0 ped low, 1 ped held high, 2 ped toggled on every tick
  task automatic ticks(input int n, input int pm);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        tick = (k == 3);
        if (pm == 1) ped_req = 1'b1;
        else if (pm == 2) begin
          if (k == 3) ped_req = ~ped_req;
        end else ped_req = 1'b0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tick = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input int s, input int nl,
                         input int el, input int w);
    chk({nm, "_state"}, int'(state), s);
    chk({nm, "_ns"}, int'(ns_light), nl);
    chk({nm, "_ew"}, int'(ew_light), el);
    chk({nm, "_walk"}, int'(walk), w);
  endtask

  initial begin
    int pm;
    pm = PED ? 0 : 2;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 5, 1, 1, 0);
    @(negedge clk);
    reset = 1'b0;
    cmp_en = 1'b1;

    ticks(1, pm);  chk_all("first_nsg", 0, 3, 1, 0);
    ticks(8, pm);  chk_all("nsy", 1, 2, 1, 0);
    ticks(3, pm);  chk_all("allred_a", 2, 1, 1, 0);
    ticks(1, pm);  chk_all("ewg", 3, 1, 3, 0);
    ticks(7, pm);  chk("ewg_last", int'(state), 3);
    ticks(1, pm);  chk_all("ewy", 4, 1, 2, 0);
    ticks(3, pm);  chk_all("allred_b", 5, 1, 1, 0);
    ticks(1, pm);  chk_all("wrap_nsg", 0, 3, 1, 0);

    ticks(3, pm);
    idle(100);     chk("hold_state", int'(state), 0);
    ticks(4, pm);  chk("hold_cnt", int'(state), 0);
    ticks(1, pm);  chk("hold_exit", int'(state), 1);

    ticks(3, 0);
    ticks(1, 0);
    ticks(8, 0);   chk("pre_rst_ewy", int'(state), 4);
    ticks(1, 0);
    #2;
    reset = 1'b1;
    #1;
    chk_all("midrst", 5, 1, 1, 0);
    idle(3);
    @(negedge clk);
    reset = 1'b0;
    ticks(1, 0);   chk_all("rst_nsg", 0, 3, 1, 0);

`ifdef TLIGHT_PED_EN
    @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    ticks(1, 0);   chk("ped_g1", int'(state), 0);
    ticks(1, 0);   chk("ped_early", int'(state), 1);
    ticks(3, 0);   chk("ped_ara", int'(state), 2);
    ticks(1, 0);   chk_all("ped_walk", 6, 1, 1, 1);
    ticks(3, 0);   chk("ped_walk3", int'(state), 6);
    ticks(1, 0);   chk_all("ped_ewg", 3, 1, 3, 0);
    ticks(2, 1);   chk("held_ewy", int'(state), 4);
    ticks(3, 1);   chk("held_arb", int'(state), 5);
    ticks(1, 1);   chk("held_walk", int'(state), 6);
    ticks(4, 0);   chk("held_nsg", int'(state), 0);
    ticks(7, 0);   chk("no_early", int'(state), 0);
    ticks(1, 0);   chk("full_nsg", int'(state), 1);
    ticks(3, 0);
    ticks(1, 0);   chk("no_walk2", int'(state), 3);
`else
    ticks(8, 2);   chk("tog_nsy", int'(state), 1);
    ticks(4, 2);   chk("tog_ewg", int'(state), 3);
`endif

    idle(2);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlight_ctrl.md
TLIGHT_CTRL -- requirements
Module: tlight_ctrl

Interface
REQ-001 SHALL have parameter TICKS_GREEN, default 8, meaning green phase length in ticks (>=1).
REQ-002 SHALL have parameter TICKS_YELLOW, default 3, meaning yellow phase length in ticks (>=1).
REQ-003 SHALL have parameter TICKS_ALLRED, default 1, meaning all-red clearance length in ticks (>=1).
REQ-004 SHALL have parameter TICKS_WALK, default 4, meaning pedestrian walk length in ticks (>=1).
REQ-005 SHALL have parameter TICKS_MIN_GREEN, default 2, meaning minimum green before early termination (1..TICKS_GREEN).
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port tick, input, 1, one-cycle timebase pulse (frame start from VGA timing).
REQ-009 SHALL have port ped_req, input, 1, pedestrian button level, synchronous to clk.
REQ-010 SHALL have port ns_light, output, 2, north-south lamp: 0 off, 1 red, 2 yellow, 3 green.
REQ-011 SHALL have port ew_light, output, 2, east-west lamp, same encoding.
REQ-012 SHALL have port walk, output, 1, pedestrian walk lamp.
REQ-013 SHALL have port state, output, 3, current FSM state code for the renderer.

Function
REQ-014 SHALL implement states NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5, PED_WALK=6.
REQ-015 SHALL hold a phase counter sized $clog2(max tick parameter + 1), cleared on every state change.
REQ-016 SHALL advance the counter only on cycles with tick=1; no tick, no change to counter or state.
REQ-017 SHALL leave a state on the tick where counter == length-1 for that state; counter returns to 0 the same edge.
REQ-018 SHALL sequence NS_GREEN->NS_YELLOW->ALLRED_A->EW_GREEN->EW_YELLOW->ALLRED_B->NS_GREEN when no pedestrian request is pending.
REQ-019 SHALL drive lamps registered from state: green/yellow states drive own direction 3/2 and the other 1; ALLRED_x and PED_WALK drive both 1.
REQ-020 SHALL latch ped_req=1 into a pending flag on any cycle not in PED_WALK; ped_req during PED_WALK is ignored.
REQ-021 SHALL, with pending set, end a green state on the tick where counter >= TICKS_MIN_GREEN-1, going to that direction's yellow.
REQ-022 SHALL, with pending set at the exit tick of ALLRED_A or ALLRED_B, go to PED_WALK instead of the next green, and clear pending on that edge.
REQ-023 SHALL leave PED_WALK after TICKS_WALK ticks to the green that the originating ALLRED state would have entered (ALLRED_A->EW_GREEN, ALLRED_B->NS_GREEN).
REQ-024 SHALL assert walk exactly while state==PED_WALK, registered, same cycle as state output.
REQ-025 SHALL give priority to the exit decision when tick and a new ped_req coincide: ped_req sets pending, the transition uses pending as registered before that edge.
REQ-026 SHALL have one-cycle latency from the deciding tick edge to updated state, lamps and walk.

Reset
REQ-027 SHALL, on reset asserted, immediately set state=ALLRED_B, counter=0, pending=0, ns_light=1, ew_light=1, walk=0.
REQ-028 SHALL, on reset mid-phase, abandon the phase; first phase after release is ALLRED_B then NS_GREEN.

Configuration
REQ-029 SHALL compile the pedestrian feature only when macro TLIGHT_PED_EN is defined.
REQ-030 SHALL, without TLIGHT_PED_EN, ignore ped_req, omit pending and PED_WALK, tie walk=0, and run only the REQ-018 cycle.

Verification
REQ-031 Defaults 8/3/1, tick every 4 clk, no ped_req -> NS_GREEN 8 ticks, NS_YELLOW 3, ALLRED_A 1, EW_GREEN 8, repeating; ns/ew lamp codes match REQ-019.
REQ-032 tick held 0 for 100 clk in NS_GREEN -> state and counter unchanged.
REQ-033 TLIGHT_PED_EN, ped_req pulse at NS_GREEN counter=0 -> green ends after 2 ticks, NS_YELLOW 3, ALLRED_A 1, PED_WALK 4 with walk=1 and lamps 1/1, then EW_GREEN.
REQ-034 TLIGHT_PED_EN, ped_req held through PED_WALK -> no second PED_WALK until the next ALLRED after a fresh press outside PED_WALK.
REQ-035 Reset asserted mid EW_YELLOW between clk edges -> outputs immediately 1/1, walk=0, state=5; after release, 1 tick later NS_GREEN.
REQ-036 Without TLIGHT_PED_EN, ped_req toggled every tick -> sequence identical to REQ-031, walk always 0.
